std_bypass_responder: RTL and testbench

Memory-side responder for the standard data cache's uncached (bypass) request channel. It accepts one bypass request at a time (request/id/addr/wdata/we/be/size) and grants it. It then runs the access on a simple single-outstanding memory port and returns a one-cycle response (valid/rdata/id/err) to the cache. The block sits between the cache's bypass arbiter and the uncached memory/peripheral fabric, and adds alignment checking and a response timeout.

---
 rtl/std_bypass_responder.sv | 111 +++++++++++
 tb/tb_std_bypass_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/std_bypass_responder.sv
// std_bypass_responder: single-outstanding uncached request responder with alignment check and timeout
module std_bypass_responder #(
  parameter int AddrWidth     = 64,
  parameter int DataWidth     = 64,
  parameter int IdWidth       = 4,
  parameter int TimeoutCycles = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic [IdWidth-1:0]     req_id_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   req_we_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  input  logic [1:0]             req_size_i,
  output logic                   rsp_gnt_o,
  output logic                   rsp_valid_o,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic [IdWidth-1:0]     rsp_id_o,
  output logic                   rsp_err_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  input  logic                   mem_err_i,
  output logic                   busy_o
);
  localparam int CW = $clog2(TimeoutCycles);
  typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, RESP, DRAIN} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt;
  logic drain;
  logic [IdWidth-1:0] id_q;
  logic [AddrWidth-4:0] addr_q;
  logic we_q;
  logic [DataWidth-1:0] wdata_q, rdata_q;
  logic [DataWidth/8-1:0] be_q;
  logic err_q;
  logic mis, tmo;
  assign mis = (req_size_i == 2'd1 && req_addr_i[0]) ||
               (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b0) ||
               (req_size_i == 2'd3 && req_addr_i[2:0] != 3'b0);
  assign tmo = cnt == CW'(TimeoutCycles - 1);
  assign rsp_gnt_o   = state == IDLE && req_i;
  assign rsp_valid_o = state == RESP;
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_id_o    = rsp_valid_o ? id_q : '0;
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign mem_req_o   = state == MEM_REQ;
  assign mem_addr_o  = mem_req_o ? {addr_q, 3'b0} : '0;
  assign mem_we_o    = mem_req_o && we_q;
  assign mem_be_o    = mem_req_o ? be_q : '0;
  assign mem_wdata_o = mem_req_o ? wdata_q : '0;
  assign busy_o      = state != IDLE;
  // state register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= nstate;
  // next-state: misaligned requests skip memory, a timeout forces a drain of the late response
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:     if (req_i) nstate = mis ? RESP : MEM_REQ;
      MEM_REQ:  if (mem_gnt_i) nstate = MEM_WAIT;
      MEM_WAIT: if (mem_rvalid_i || tmo) nstate = RESP;
      RESP:     nstate = drain ? DRAIN : IDLE;
      DRAIN:    if (mem_rvalid_i) nstate = IDLE;
      default:  nstate = IDLE;
    endcase
  end
  // request latch, timeout counter and response capture
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt <= '0;
      drain <= 1'b0;
      id_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      be_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && req_i) begin
        id_q <= req_id_i;
        addr_q <= req_addr_i[AddrWidth-1:3];
        we_q <= req_we_i;
        wdata_q <= req_wdata_i;
        be_q <= req_be_i;
        rdata_q <= '0;
        err_q <= mis;
      end
      if (state == MEM_REQ && mem_gnt_i) cnt <= '0;
      if (state == MEM_WAIT) begin
        if (mem_rvalid_i) begin
          rdata_q <= we_q ? '0 : mem_rdata_i;
          err_q <= mem_err_i;
        end else if (tmo) begin
          rdata_q <= '0;
          err_q <= 1'b1;
          drain <= 1'b1;
        end else cnt <= cnt + 1'b1;
      end
      if (state == DRAIN && mem_rvalid_i) drain <= 1'b0;
    end
endmodule

// File: tb/tb_std_bypass_responder.sv
// tb_std_bypass_responder: table, random and reset-sequence checks of the bypass responder
module tb_std_bypass_responder;
  localparam int TC = 8;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic req_i = 1'b0, req_we_i = 1'b0, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
  logic [3:0] req_id_i = '0;
  logic [63:0] req_addr_i = '0, req_wdata_i = '0, mem_rdata_i = '0;
  logic [7:0] req_be_i = '0;
  logic [1:0] req_size_i = '0;
  logic rsp_gnt_o, rsp_valid_o, rsp_err_o, mem_req_o, mem_we_o, busy_o;
  logic [63:0] rsp_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0] rsp_id_o;
  logic [7:0] mem_be_o;
  int cmp = 0, errs = 0;

  std_bypass_responder #(.AddrWidth(64), .DataWidth(64), .IdWidth(4), .TimeoutCycles(TC)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .req_id_i(req_id_i), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i), .req_size_i(req_size_i),
    .rsp_gnt_o(rsp_gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_id_o(rsp_id_o),
    .rsp_err_o(rsp_err_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .busy_o(busy_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] id; logic [63:0] addr; logic we; logic [63:0] wdata; logic [7:0] be; logic [1:0] size;
    int gd; int rd; logic [63:0] rdata; logic merr;
    logic acc; logic exp_err; logic [63:0] exp_rdata; int exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    bit mis, tmo;
    int g;
    mis = (v.addr & ((64'd1 << v.size) - 64'd1)) != 64'd0;
    tmo = !mis && v.rd >= TC;
    g = 1 + v.gd;
    v.acc = !mis;
    v.exp_err = mis || tmo || v.merr;
    v.exp_rdata = (mis || tmo || v.we) ? 64'd0 : v.rdata;
    v.exp_lat = mis ? 1 : tmo ? g + TC + 1 : g + 1 + v.rd + 1;
    return v;
  endfunction

  task automatic run(input vec_t v);
    int end_k, rv_k;
    logic [63:0] lat_addr;
    rv_k = 2 + v.gd + v.rd;
    end_k = (v.acc && rv_k > v.exp_lat) ? rv_k : v.exp_lat;
    lat_addr = v.addr & ~64'd7;
    for (int k = 0; k <= end_k; k++) begin
      @(negedge clk);
      req_i = 1'b1;
      req_id_i = k == 0 ? v.id : 4'($urandom);
      req_addr_i = k == 0 ? v.addr : {$urandom, $urandom};
      req_we_i = k == 0 ? v.we : 1'($urandom);
      req_wdata_i = k == 0 ? v.wdata : {$urandom, $urandom};
      req_be_i = k == 0 ? v.be : 8'($urandom);
      req_size_i = k == 0 ? v.size : 2'($urandom);
      mem_gnt_i = v.acc && k == 1 + v.gd;
      mem_rvalid_i = v.acc && k == rv_k;
      mem_rdata_i = mem_rvalid_i ? v.rdata : {$urandom, $urandom};
      mem_err_i = mem_rvalid_i ? v.merr : 1'($urandom);
      #1;
      chk("gnt", 64'(rsp_gnt_o), 64'(k == 0));
      chk("rsp_valid", 64'(rsp_valid_o), 64'(k == v.exp_lat));
      chk("mem_req", 64'(mem_req_o), 64'(v.acc && k >= 1 && k <= 1 + v.gd));
      chk("busy", 64'(busy_o), 64'(k >= 1));
      if (k == v.exp_lat) begin
        chk("rsp_rdata", rsp_rdata_o, v.exp_rdata);
        chk("rsp_id", 64'(rsp_id_o), 64'(v.id));
        chk("rsp_err", 64'(rsp_err_o), 64'(v.exp_err));
      end else chk("rsp_idle_zero", {rsp_rdata_o[58:0], rsp_id_o, rsp_err_o}, 64'd0);
      if (v.acc && k >= 1 && k <= 1 + v.gd) begin
        chk("mem_addr", mem_addr_o, lat_addr);
        chk("mem_we", 64'(mem_we_o), 64'(v.we));
        chk("mem_be", 64'(mem_be_o), 64'(v.be));
        chk("mem_wdata", mem_wdata_o, v.wdata);
      end
    end
    @(negedge clk);
    req_i = 1'b0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  task automatic chk_reset_outs(input logic exp_gnt);
    chk("rst_gnt", 64'(rsp_gnt_o), 64'(exp_gnt));
    chk("rst_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_rsp", {rsp_rdata_o[58:0], rsp_id_o, rsp_err_o}, 64'd0);
    chk("rst_mem", mem_addr_o | mem_wdata_o | 64'(mem_be_o) | 64'(mem_we_o), 64'd0);
  endtask

  vec_t tbl[9];
  vec_t v;

  initial begin
    tbl[0] = '{4'h3, 64'h1000, 1'b0, 64'h0, 8'hFF, 2'd3, 0, 0, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D, 3};
    tbl[1] = '{4'h5, 64'h2004, 1'b1, 64'h11223344_00000000, 8'hF0, 2'd2, 5, 1, 64'hFFFF, 1'b0, 1'b1, 1'b0, 64'h0, 9};
    tbl[2] = '{4'h7, 64'h3002, 1'b0, 64'h0, 8'h0C, 2'd2, 0, 0, 64'h1234, 1'b0, 1'b0, 1'b1, 64'h0, 1};
    tbl[3] = '{4'h9, 64'h4000, 1'b0, 64'h0, 8'hFF, 2'd3, 0, 10, 64'hAAAA, 1'b0, 1'b1, 1'b1, 64'h0, 10};
    tbl[4] = '{4'hA, 64'h5008, 1'b0, 64'h0, 8'hFF, 2'd3, 1, 2, 64'h01234567_89ABCDEF, 1'b1, 1'b1, 1'b1, 64'h01234567_89ABCDEF, 6};
    tbl[5] = '{4'hB, 64'h6001, 1'b1, 64'h0, 8'h03, 2'd1, 0, 0, 64'h0, 1'b0, 1'b0, 1'b1, 64'h0, 1};
    tbl[6] = '{4'hC, 64'h7003, 1'b0, 64'h0, 8'h08, 2'd0, 2, 7, 64'h55, 1'b0, 1'b1, 1'b0, 64'h55, 12};
    tbl[7] = '{4'hD, 64'h8004, 1'b0, 64'h0, 8'hFF, 2'd3, 0, 0, 64'h0, 1'b0, 1'b0, 1'b1, 64'h0, 1};
    tbl[8] = '{4'hE, 64'h9000, 1'b1, 64'hCAFE, 8'hFF, 2'd3, 0, 0, 64'h77, 1'b1, 1'b1, 1'b1, 64'h0, 3};
    #1;
    chk_reset_outs(1'b0);
    @(negedge clk);
    req_i = 1'b1;
    #1;
    chk_reset_outs(1'b1);
    req_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    foreach (tbl[i]) run(tbl[i]);
    for (int n = 0; n < 40; n++) begin
      v.id = 4'($urandom);
      v.size = 2'($urandom);
      v.addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) v.addr = v.addr & ~((64'd1 << v.size) - 64'd1);
      v.we = 1'($urandom);
      v.wdata = {$urandom, $urandom};
      v.be = 8'($urandom);
      v.gd = $urandom_range(0, 4);
      v.rd = $urandom_range(0, 3) == 0 ? TC + 1 + $urandom_range(0, 3) : $urandom_range(0, TC - 1);
      v.rdata = {$urandom, $urandom};
      v.merr = $urandom_range(0, 3) == 0;
      run(model(v));
    end
    @(negedge clk);
    req_i = 1'b1; req_id_i = 4'h6; req_addr_i = 64'hA000; req_we_i = 1'b0; req_size_i = 2'd3;
    @(negedge clk);
    req_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    #1;
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    req_i = 1'b1;
    #1;
    chk_reset_outs(1'b1);
    @(negedge clk);
    req_i = 1'b0;
    #1;
    chk_reset_outs(1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hBAD; mem_err_i = 1'b1;
    #1;
    chk("post_rst_valid", 64'(rsp_valid_o), 64'd0);
    @(negedge clk);
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    #1;
    chk("post_rst_idle", {62'd0, rsp_valid_o, busy_o}, 64'd0);
    run(tbl[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
